// File: rtl/icu_param_if.sv
// ---------------------------------------------------------------------------
// icu_param_if
// Bundles the signals between the interrupt control unit and its environment.
//   i_interrupt  peripheral interrupt request lines (line 0 is bit 0)
//   i_cs/i_we    register chip select / write enable
//   i_addr       register address
//   i_data       register write data
//   o_data       registered read data
//   i_inta       CPU interrupt acknowledge (acts on its rising edge)
//   o_intr       registered interrupt request to the CPU
//   o_vector     registered vector of the acknowledged line
// The master modport is the CPU/peripheral side; the slave modport is the ICU.
// ---------------------------------------------------------------------------
interface icu_param_if #(
    parameter int N_IRQ = 8,
    parameter int DW    = 8,
    parameter int VEC_W = 8
);
    logic [N_IRQ-1:0] i_interrupt;
    logic             i_cs;
    logic             i_we;
    logic [2:0]       i_addr;
    logic [DW-1:0]    i_data;
    logic [DW-1:0]    o_data;
    logic             i_inta;
    logic             o_intr;
    logic [VEC_W-1:0] o_vector;

    modport master (
        output i_interrupt, i_cs, i_we, i_addr, i_data, i_inta,
        input  o_data, o_intr, o_vector
    );

    modport slave (
        input  i_interrupt, i_cs, i_we, i_addr, i_data, i_inta,
        output o_data, o_intr, o_vector
    );
endinterface

// File: rtl/icu_param.sv
// ---------------------------------------------------------------------------
// icu_param
// Parametrised interrupt control unit between peripheral IRQ lines and the CPU.
// Per-line edge/level capture, fixed or rotating priority, nested in-service
// masking, programmable vector base, specific and non-specific EOI.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      icu_param_if.slave: register port, IRQ lines, INTA handshake
// Register map: 0 IMR, 1 MODE (1 = level), 2 VBASE, 3 EOI (wo), 4 IRR (ro),
//               5 ISR (ro), 6 CTRL (bit0 = rotate). Other addresses read 0.
// ---------------------------------------------------------------------------
module icu_param #(
    parameter int N_IRQ = 8,
    parameter int DW    = 8,
    parameter int VEC_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    icu_param_if.slave  bus
);
    localparam int             IW   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam logic [IW-1:0]  LAST = IW'(N_IRQ - 1);

    logic [N_IRQ-1:0] imr, mode, irr, isr, irq_prev;
    logic [VEC_W-1:0] vbase;
    logic             rotate;
    logic [IW-1:0]    ptr;
    logic             inta_prev;
    logic             intr_q;
    logic [VEC_W-1:0] vector_q;
    logic [DW-1:0]    data_q;

    logic [N_IRQ-1:0] pending;
    logic [IW-1:0]    base, cand, isr_top, sel;
    logic             cand_vld, isr_vld;
    int               idx;

    assign pending = irr & ~imr;

    // Walk the lines in priority order. A pending line only qualifies if it is
    // met before any in-service line, i.e. strictly higher than every ISR bit.
    always_comb begin
        base     = '0;
        cand     = '0;
        cand_vld = 1'b0;
        isr_top  = '0;
        isr_vld  = 1'b0;
        idx      = 0;
        sel      = '0;
        if (rotate && ptr != LAST)
            base = ptr + IW'(1);
        for (int i = 0; i < N_IRQ; i++) begin
            idx = int'(base) + i;
            if (idx >= N_IRQ)
                idx = idx - N_IRQ;
            sel = IW'(idx);
            if (isr[sel] && !isr_vld) begin
                isr_vld = 1'b1;
                isr_top = sel;
            end
            if (pending[sel] && !isr_vld && !cand_vld) begin
                cand_vld = 1'b1;
                cand     = sel;
            end
        end
    end

    logic             wr, rd, eoi_wr, inta_rise, ack, spur;
    logic [N_IRQ-1:0] ack_mask, eoi_mask, edge_set, irr_next;
    logic             eoi_upd;
    logic [IW-1:0]    eoi_line;
    logic [DW-1:0]    rd_mux;

    assign wr        = bus.i_cs & bus.i_we;
    assign rd        = bus.i_cs & ~bus.i_we;
    assign eoi_wr    = wr && (bus.i_addr == 3'd3);
    assign inta_rise = bus.i_inta & ~inta_prev;
    // An acknowledge needs a request on the line and a candidate still present.
    assign ack       = inta_rise & intr_q & cand_vld;
    assign spur      = inta_rise & ~ack;
    assign edge_set  = bus.i_interrupt & ~irq_prev;
    // Edge lines: a fresh edge wins over the acknowledge clear of the same line.
    assign irr_next  = (mode & bus.i_interrupt) |
                       (~mode & ((irr & ~ack_mask) | edge_set));

    always_comb begin
        ack_mask = '0;
        if (ack)
            ack_mask[cand] = 1'b1;
    end

    always_comb begin
        eoi_mask = '0;
        eoi_upd  = 1'b0;
        eoi_line = '0;
        if (eoi_wr) begin
            if (bus.i_data[DW-1]) begin
                if (isr_vld) begin
                    eoi_mask[isr_top] = 1'b1;
                    eoi_upd           = 1'b1;
                    eoi_line          = isr_top;
                end
            end else begin
                for (int k = 0; k < N_IRQ; k++) begin
                    if (int'(bus.i_data[2:0]) == k && isr[k]) begin
                        eoi_mask[k] = 1'b1;
                        eoi_upd     = 1'b1;
                        eoi_line    = IW'(k);
                    end
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.i_addr)
            3'd0:    rd_mux = DW'(imr);
            3'd1:    rd_mux = DW'(mode);
            3'd2:    rd_mux = DW'(vbase);
            3'd4:    rd_mux = DW'(irr);
            3'd5:    rd_mux = DW'(isr);
            3'd6:    rd_mux = DW'(rotate);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            imr       <= '1;
            mode      <= '0;
            vbase     <= VEC_W'(32'h20);
            rotate    <= 1'b0;
            irr       <= '0;
            isr       <= '0;
            irq_prev  <= '0;
            ptr       <= LAST;
            inta_prev <= 1'b0;
            intr_q    <= 1'b0;
            vector_q  <= '0;
            data_q    <= '0;
        end else begin
            irq_prev  <= bus.i_interrupt;
            inta_prev <= bus.i_inta;
            irr       <= irr_next;
            // Acknowledge uses the pre-EOI ISR; both updates merge here.
            isr       <= (isr & ~eoi_mask) | ack_mask;
            intr_q    <= cand_vld & ~ack;
            if (eoi_upd)
                ptr <= eoi_line;
            if (ack)
                vector_q <= vbase + VEC_W'(cand);
            else if (spur)
                vector_q <= vbase + VEC_W'(N_IRQ);
            if (rd)
                data_q <= rd_mux;
            if (wr) begin
                case (bus.i_addr)
                    3'd0:    imr    <= bus.i_data[N_IRQ-1:0];
                    3'd1:    mode   <= bus.i_data[N_IRQ-1:0];
                    3'd2:    vbase  <= VEC_W'(bus.i_data);
                    3'd6:    rotate <= bus.i_data[0];
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_intr   = intr_q;
    assign bus.o_vector = vector_q;
    assign bus.o_data   = data_q;
endmodule

// File: tb/tb_icu_param.sv
// ---------------------------------------------------------------------------
// tb_icu_param
// Directed bench for icu_param (N_IRQ = DW = VEC_W = 8). Inputs change 1 ns
// after the rising edge; outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_icu_param;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    icu_param_if #(.N_IRQ(8), .DW(8), .VEC_W(8)) bus ();

    icu_param #(.N_IRQ(8), .DW(8), .VEC_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        bus.i_cs = 1'b1; bus.i_we = 1'b1; bus.i_addr = a; bus.i_data = d;
        tick();
        bus.i_cs = 1'b0; bus.i_we = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
        bus.i_cs = 1'b1; bus.i_we = 1'b0; bus.i_addr = a;
        tick();
        bus.i_cs = 1'b0;
        d = bus.o_data;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd_reg(a, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    // Bounded wait for o_intr; the final check reports a timeout.
    task automatic wait_intr(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (bus.o_intr) break;
            tick();
        end
        check(tag, 32'(bus.o_intr), 32'd1);
    endtask

    // Acknowledge: the vector is sampled right after the edge that sees INTA rise.
    task automatic inta(input string tag, input logic [7:0] exp_vec);
        bus.i_inta = 1'b1;
        tick();
        check(tag, 32'(bus.o_vector), 32'(exp_vec));
        bus.i_inta = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic [7:0] lines);
        bus.i_interrupt = lines;
        tick();
        bus.i_interrupt = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.i_interrupt = '0; bus.i_cs = 1'b0; bus.i_we = 1'b0;
        bus.i_addr = '0; bus.i_data = '0; bus.i_inta = 1'b0;
        tick(); tick();
        check("rst_intr", 32'(bus.o_intr), 32'd0);
        check("rst_vec", 32'(bus.o_vector), 32'd0);
        check("rst_data", 32'(bus.o_data), 32'd0);
        rst_n = 1'b1;
        tick();
        rd_check("rst_imr", 3'd0, 8'hFF);
        rd_check("rst_mode", 3'd1, 8'h00);
        rd_check("rst_vbase", 3'd2, 8'h20);
        rd_check("rst_ctrl", 3'd6, 8'h00);
        rd_check("rst_irr", 3'd4, 8'h00);
        rd_check("rst_isr", 3'd5, 8'h00);
        rd_check("undef_addr", 3'd7, 8'h00);

        // 1) single edge line
        wr_reg(3'd0, 8'h00);
        pulse(8'h01);
        wait_intr("t1_intr", 2);
        inta("t1_vec", 8'h20);
        rd_check("t1_isr", 3'd5, 8'h01);
        rd_check("t1_irr", 3'd4, 8'h00);
        wr_reg(3'd3, 8'h80);
        rd_check("t1_isr_eoi", 3'd5, 8'h00);

        // 2) fixed priority and nesting
        pulse(8'h24);
        wait_intr("t2_intr", 3);
        inta("t2_vec2", 8'h22);
        tick(); tick();
        check("t2_held", 32'(bus.o_intr), 32'd0);
        rd_check("t2_irr", 3'd4, 8'h20);
        wr_reg(3'd3, 8'h80);
        wait_intr("t2_intr5", 3);
        inta("t2_vec5", 8'h25);
        wr_reg(3'd3, 8'h80);

        // 3) rotating priority
        wr_reg(3'd6, 8'h01);
        pulse(8'h08);
        wait_intr("t3_intr3", 3);
        inta("t3_vec3", 8'h23);
        wr_reg(3'd3, 8'h03);
        rd_check("t3_isr", 3'd5, 8'h00);
        pulse(8'h11);
        wait_intr("t3_intr", 3);
        inta("t3_vec4", 8'h24);
        wr_reg(3'd3, 8'h80);
        wait_intr("t3_intr0", 3);
        inta("t3_vec0", 8'h20);
        wr_reg(3'd3, 8'h80);
        wr_reg(3'd6, 8'h00);

        // 4) level line
        wr_reg(3'd1, 8'h40);
        bus.i_interrupt = 8'h40;
        wait_intr("t4_intr", 3);
        inta("t4_vec", 8'h26);
        check("t4_masked", 32'(bus.o_intr), 32'd0);
        wr_reg(3'd3, 8'h80);
        wait_intr("t4_reassert", 3);
        inta("t4_vec2", 8'h26);
        bus.i_interrupt = 8'h00;
        tick();
        rd_check("t4_irr_drop", 3'd4, 8'h00);
        wr_reg(3'd3, 8'h80);
        tick(); tick();
        check("t4_no_intr", 32'(bus.o_intr), 32'd0);
        wr_reg(3'd1, 8'h00);

        // 5) spurious acknowledge and vector wrap
        inta("t5_spur", 8'h28);
        rd_check("t5_irr", 3'd4, 8'h00);
        rd_check("t5_isr", 3'd5, 8'h00);
        wr_reg(3'd2, 8'hFE);
        rd_check("t5_vbase", 3'd2, 8'hFE);
        pulse(8'h08);
        wait_intr("t5_intr", 3);
        inta("t5_wrap", 8'h01);
        wr_reg(3'd3, 8'h03);

        // new edge on the line being acknowledged keeps it pending
        pulse(8'h02);
        wait_intr("sim_intr", 3);
        bus.i_inta = 1'b1;
        bus.i_interrupt = 8'h02;
        tick();
        check("sim_vec", 32'(bus.o_vector), 32'hFF);
        bus.i_inta = 1'b0;
        bus.i_interrupt = 8'h00;
        tick();
        rd_check("sim_irr", 3'd4, 8'h02);
        rd_check("sim_isr", 3'd5, 8'h02);
        check("sim_blocked", 32'(bus.o_intr), 32'd0);
        wr_reg(3'd3, 8'h80);
        wait_intr("sim_reassert", 3);
        inta("sim_vec2", 8'hFF);
        wr_reg(3'd3, 8'h80);

        // 6) reset in the middle of a handshake
        pulse(8'h04);
        wait_intr("t6_intr", 3);
        bus.i_inta = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("t6_intr", 32'(bus.o_intr), 32'd0);
        check("t6_vec", 32'(bus.o_vector), 32'd0);
        bus.i_inta = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        rd_check("t6_imr", 3'd0, 8'hFF);
        rd_check("t6_isr", 3'd5, 8'h00);
        rd_check("t6_vbase", 3'd2, 8'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
